// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption sequencer: runs the initial AddRoundKey, then steps an external
// round datapath and key-schedule step through rounds 1..10, and hands off the ciphertext.
module aes128_round_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_text,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text,
  output logic         busy,
  output logic [127:0] rnd_state,
  output logic [127:0] rnd_key,
  output logic         rnd_last,
  input  logic [127:0] rnd_result,
  output logic [127:0] ks_key,
  output logic [7:0]   ks_rcon,
  input  logic [127:0] ks_next
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} st_e;

  st_e          st_q, st_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   round_q, round_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= StIdle;
      state_q <= '0;
      key_q   <= '0;
      rcon_q  <= '0;
      round_q <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    unique case (st_q)
      StIdle: begin
        if (in_valid) begin
          state_d = in_text ^ in_key;
          key_d   = in_key;
          rcon_d  = 8'h01;
          round_d = 4'd1;
          st_d    = StRun;
        end
      end
      StRun: begin
        state_d = rnd_result;
        key_d   = ks_next;
        // xtime: doubling in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
        rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        round_d = round_q + 4'd1;
        if (round_q == 4'd10) begin
          st_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          st_d = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  // Gated by rst so no offer can look accepted while the block is held in reset.
  assign in_ready  = (st_q == StIdle) && !rst;
  assign out_valid = (st_q == StDone);
  assign busy      = (st_q == StRun) || (st_q == StDone);
  assign out_text  = state_q;

  assign rnd_state = state_q;
  assign rnd_key   = ks_next;
  assign rnd_last  = (round_q == 4'd10);
  assign ks_key    = key_q;
  assign ks_rcon   = rcon_q;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Bench for aes128_round_ctrl: supplies behavioural round/key-schedule units and compares the
// ciphertext with FIPS-197 vectors and a whole-cipher reference function.
module tb_aes128_round_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_text = '0;
  logic [127:0] in_key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_text;
  logic         busy;
  logic [127:0] rnd_state, rnd_key, rnd_result, ks_key, ks_next;
  logic         rnd_last;
  logic [7:0]   ks_rcon;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rcon_exp [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  aes128_round_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_text    (in_text),
    .in_key     (in_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_text   (out_text),
    .busy       (busy),
    .rnd_state  (rnd_state),
    .rnd_key    (rnd_key),
    .rnd_last   (rnd_last),
    .rnd_result (rnd_result),
    .ks_key     (ks_key),
    .ks_rcon    (ks_rcon),
    .ks_next    (ks_next)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                            input logic last);
    logic [127:0] t;
    t = shift_rows(sub_bytes(s));
    if (!last) t = mix_columns(t);
    return t ^ k;
  endfunction

  // Whole-cipher reference: full 44-word key expansion, then the ten rounds in a loop.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc = 8'h01;
    logic [127:0] s;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      s = shift_rows(sub_bytes(s));
      if (r < 10) s = mix_columns(s);
      s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  always_comb ks_next = key_step(ks_key, ks_rcon);
  always_comb rnd_result = round_fn(rnd_state, rnd_key, rnd_last);

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offers a vector, waits (bounded) for in_ready and returns #1 after the accept edge.
  task automatic start_block(input logic [127:0] pt, input logic [127:0] key, input int max_wait,
                             output int waited);
    in_text  = pt;
    in_key   = key;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < max_wait) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_eq("accept_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_rounds();
    for (int i = 0; i < 10; i++) begin
      check_eq("rcon", 128'(ks_rcon), 128'(rcon_exp[i]));
      check_eq("rnd_last", 128'(rnd_last), 128'(i == 9));
      check_eq("busy_run", 128'(busy), 128'(1));
      check_eq("early_valid", 128'(out_valid), 128'(0));
      check_eq("ready_in_run", 128'(in_ready), 128'(0));
      @(posedge clk);
      #1;
    end
    check_eq("latency_valid", 128'(out_valid), 128'(1));
  endtask

  task automatic finish_block(input logic [127:0] exp, input int hold);
    check_eq("out_text", out_text, exp);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_valid", 128'(out_valid), 128'(1));
      check_eq("hold_text", out_text, exp);
      check_eq("hold_in_ready", 128'(in_ready), 128'(0));
      check_eq("hold_busy", 128'(busy), 128'(1));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("post_valid", 128'(out_valid), 128'(0));
    check_eq("post_busy", 128'(busy), 128'(0));
    check_eq("post_in_ready", 128'(in_ready), 128'(1));
  endtask

  initial begin
    int           waited;
    logic [127:0] p1, k1, p2, k2;
    logic [127:0] bp [4];
    logic [127:0] bk [4];
    logic [127:0] exp_q [$];
    int           idx, got, last_cyc;
    bit           acc, seen_valid;

    // Reset state
    #2;
    check_eq("rst_in_ready", 128'(in_ready), 128'(0));
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_out_text", out_text, 128'(0));
    @(posedge clk);
    #1;
    check_eq("rst_in_ready_held", 128'(in_ready), 128'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("idle_in_ready", 128'(in_ready), 128'(1));

    // FIPS-197 C.1
    start_block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                5, waited);
    run_rounds();
    finish_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);

    // FIPS-197 B
    start_block(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                5, waited);
    run_rounds();
    finish_block(128'h3925841d02dc09fbdc118597196a0b32, 0);

    // Backpressure with a second offer held during DONE
    p1 = rand128(); k1 = rand128(); p2 = rand128(); k2 = rand128();
    start_block(p1, k1, 5, waited);
    run_rounds();
    in_text  = p2;
    in_key   = k2;
    in_valid = 1'b1;
    finish_block(aes_ref(p1, k1), 5);
    start_block(p2, k2, 5, waited);
    check_eq("second_accept_wait", 128'(waited), 128'(0));
    run_rounds();
    finish_block(aes_ref(p2, k2), 0);

    // Reset in round 5
    start_block(rand128(), rand128(), 5, waited);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("pre_rst_rcon", 128'(ks_rcon), 128'(8'h10));
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_in_ready", 128'(in_ready), 128'(0));
    check_eq("mid_rst_valid", 128'(out_valid), 128'(0));
    check_eq("mid_rst_busy", 128'(busy), 128'(0));
    check_eq("mid_rst_text", out_text, 128'(0));
    @(posedge clk);
    #1;
    check_eq("mid_rst_in_ready2", 128'(in_ready), 128'(0));
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) seen_valid = 1'b1;
    end
    check_eq("no_partial_valid", 128'(seen_valid), 128'(0));
    p1 = rand128(); k1 = rand128();
    start_block(p1, k1, 2, waited);
    run_rounds();
    finish_block(aes_ref(p1, k1), 0);

    // Back-to-back with in_valid and out_ready tied high
    for (int i = 0; i < 4; i++) begin
      bp[i] = rand128();
      bk[i] = rand128();
    end
    idx = 0; got = 0; last_cyc = 0;
    out_ready = 1'b1;
    in_text   = bp[0];
    in_key    = bk[0];
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 80 && got < 4; cyc++) begin
      acc = in_ready && in_valid;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("b2b_unexpected", 128'(out_valid), 128'(0));
        end else begin
          check_eq("b2b_text", out_text, exp_q.pop_front());
        end
        if (got > 0) check_eq("b2b_period", 128'(cyc - last_cyc), 128'(12));
        last_cyc = cyc;
        got++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        exp_q.push_back(aes_ref(bp[idx], bk[idx]));
        idx++;
        if (idx < 4) begin
          in_text = bp[idx];
          in_key  = bk[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check_eq("b2b_count", 128'(got), 128'(4));
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
